// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED frame controller: register offsets, CTRL field positions,
// brightness width, bus FSM states and the brightness fade step helper.
package led_ctrl_pkg;

   localparam int unsigned PWM_W = 3;

   // Word offsets within the 16-byte register window (mem_addr[3:2])
   localparam logic [1:0] REG_BACK   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // CTRL register field positions
   localparam int unsigned CTRL_PEND_BIT = 0;
   localparam int unsigned CTRL_TGT_LSB  = 4;
   localparam int unsigned CTRL_AUTO_BIT = 8;

   typedef enum logic {
      StIdle,
      StAck
   } bus_state_e;

   // One saturating step of cur toward tgt; never wraps.
   function automatic logic [PWM_W-1:0] fade_step(input logic [PWM_W-1:0] cur,
                                                  input logic [PWM_W-1:0] tgt);
      logic [PWM_W-1:0] nxt;
      nxt = cur;
      if (cur < tgt) begin
         nxt = cur + PWM_W'(1);
      end else if (cur > tgt) begin
         nxt = cur - PWM_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Frame tick generator: free-running counter 0..TICK_DIV-1, pulses tick_o for one cycle
// while the counter sits at its terminal value.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   tick_o   one-cycle frame tick pulse
module led_tick_gen #(
   parameter int unsigned TICK_DIV = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CntMax);
      cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_frame_ctrl.sv
// Memory-mapped double-buffered frame controller for the 8x4 LED matrix.
// The CPU writes a back frame; it is copied to the displayed front frame only on a frame
// tick (on request or automatically), and brightness fades one step per tick toward target.
//   clk, reset            system clock, asynchronous active-high reset
//   mem_valid/ready       native bus handshake (ready is a one-cycle acknowledge)
//   mem_addr/wdata/wstrb  request; wstrb == 0 is a read
//   mem_rdata             read data, held until the next access
//   leds1..leds4          front frame columns, leds1 = front[7:0]
//   leds_pwm              current brightness
//   frame_tick            one-cycle tick pulse
//   swap_done             one-cycle pulse in the tick cycle that swaps
module led_frame_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned CLK_MHZ   = 12,
   parameter int unsigned FRAME_HZ  = 60,
   parameter int unsigned TICK_DIV  = CLK_MHZ * 1000000 / FRAME_HZ,
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   output logic [31:0]      mem_rdata,
   output logic [7:0]       leds1,
   output logic [7:0]       leds2,
   output logic [7:0]       leds3,
   output logic [7:0]       leds4,
   output logic [PWM_W-1:0] leds_pwm,
   output logic             frame_tick,
   output logic             swap_done
);

   bus_state_e       state_q, state_d;
   logic [31:0]      back_q, back_d;
   logic [31:0]      front_q, front_d;
   logic [PWM_W-1:0] target_q, target_d;
   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic             pending_q, pending_d;
   logic             auto_q, auto_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [31:0]      rdata_q, rdata_d;

   logic        tick;
   logic        sel, access, wr;
   logic        wr_back, wr_ctrl;
   logic        swap;
   logic [1:0]  offset;
   logic [31:0] rd_mux;
   logic        unused_addr;

   assign unused_addr = ^mem_addr[1:0];

   led_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk_i  (clk),
      .reset_i(reset),
      .tick_o (tick)
   );

   // Bus decode and handshake FSM
   always_comb begin
      sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
      offset  = mem_addr[3:2];
      access  = (state_q == StIdle) && sel;
      wr      = access && (mem_wstrb != 4'b0000);
      wr_back = wr && (offset == REG_BACK);
      wr_ctrl = wr && (offset == REG_CTRL);

      state_d = state_q;
      unique case (state_q)
         StIdle: if (sel) state_d = StAck;
         StAck:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Read mux sees register values before this cycle's write/tick updates
   always_comb begin
      rd_mux = 32'h0;
      unique case (offset)
         REG_BACK:   rd_mux = back_q;
         REG_CTRL:   rd_mux = {23'b0, auto_q, 1'b0, target_q, 3'b0, pending_q};
         REG_STATUS: rd_mux = {frame_cnt_q, 9'b0, pwm_q, 3'b0, pending_q};
         REG_RSVD:   rd_mux = 32'h0;
         default:    rd_mux = 32'h0;
      endcase
      rdata_d = access ? rd_mux : rdata_q;
   end

   // Register writes, swap and fade
   always_comb begin
      swap = tick && (pending_q || auto_q);

      back_d = back_q;
      if (wr_back) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wstrb[i]) back_d[8*i +: 8] = mem_wdata[8*i +: 8];
         end
      end

      // Front captures the pre-write back value when a write collides with a swap
      front_d     = swap ? back_q : front_q;
      frame_cnt_d = swap ? frame_cnt_q + 16'd1 : frame_cnt_q;

      // A colliding pending request is applied after the swap clears it
      pending_d = pending_q;
      if (swap) pending_d = 1'b0;
      if (wr_ctrl && mem_wstrb[0] && mem_wdata[CTRL_PEND_BIT]) pending_d = 1'b1;

      target_d = target_q;
      auto_d   = auto_q;
      if (wr_ctrl && mem_wstrb[0]) target_d = mem_wdata[CTRL_TGT_LSB +: PWM_W];
      if (wr_ctrl && mem_wstrb[1]) auto_d = mem_wdata[CTRL_AUTO_BIT];

      // Fade uses the old target when it collides with a target write
      pwm_d = tick ? fade_step(pwm_q, target_q) : pwm_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         back_q      <= 32'h0;
         front_q     <= 32'h0;
         target_q    <= '1;
         pwm_q       <= '1;
         pending_q   <= 1'b0;
         auto_q      <= 1'b0;
         frame_cnt_q <= 16'h0;
         rdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         back_q      <= back_d;
         front_q     <= front_d;
         target_q    <= target_d;
         pwm_q       <= pwm_d;
         pending_q   <= pending_d;
         auto_q      <= auto_d;
         frame_cnt_q <= frame_cnt_d;
         rdata_q     <= rdata_d;
      end
   end

   assign mem_ready  = (state_q == StAck);
   assign mem_rdata  = rdata_q;
   assign leds1      = front_q[7:0];
   assign leds2      = front_q[15:8];
   assign leds3      = front_q[23:16];
   assign leds4      = front_q[31:24];
   assign leds_pwm   = pwm_q;
   assign frame_tick = tick;
   assign swap_done  = swap;

endmodule
